rcu_vc_pipe: RTL and testbench

- Registered, per-virtual-channel successor to the combinational route computation unit; one instance sits on each router input port.
- Computes a Z-first, then X, then Y output port when a head flit arrives, with fault-aware Z detour.
- Latches the route per VC and holds it for the VC allocator until that VC's tail flit, adding wormhole route persistence.
- Mesh dimensions, VC count and input side are module parameters instead of globals.

---
 rtl/rcu_vc_pipe.sv | 219 +++++++++++++++++++++
 tb/tb_rcu_vc_pipe.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rcu_vc_pipe.sv
// Registered per-VC route computation for one mesh router input (Z, then X, then Y).
// Optional RCU_DETOUR_CNT_EN adds a saturating count of heads routed by the backup path.

package rcu_vc_pipe_pkg;
    typedef enum logic [2:0] {
        LOCAL = 3'd0,
        EAST  = 3'd1,
        WEST  = 3'd2,
        NORTH = 3'd3,
        SOUTH = 3'd4,
        UP    = 3'd5,
        DOWN  = 3'd6,
        DROP  = 3'd7
    } port_t;

    typedef struct packed {
        logic [7:0] x;
        logic [7:0] y;
        logic [7:0] z;
    } position_t;
endpackage

module rcu_vc_pipe
    import rcu_vc_pipe_pkg::*;
#(
    parameter int        MESH_WIDTH  = 4,
    parameter int        MESH_HEIGHT = 4,
    parameter int        MESH_DEPTH  = 2,
    parameter int        NUM_VCS     = 4,
    parameter port_t     IN_PORT     = LOCAL,
    parameter position_t THIS_POS    = '{x: 8'd0, y: 8'd0, z: 8'd0},
    localparam int       VCW         = (NUM_VCS > 1) ? $clog2(NUM_VCS) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   head_valid,
    input  logic [VCW-1:0]         head_vc,
    input  position_t              head_dest,
    input  logic                   tail_valid,
    input  logic [VCW-1:0]         tail_vc,
    input  logic                   up_faulty,
    input  logic                   down_faulty,
    output logic [NUM_VCS-1:0]     route_valid,
    output port_t [NUM_VCS-1:0]    route_port,
    output logic                   proto_err
`ifdef RCU_DETOUR_CNT_EN
    ,
    output logic [15:0]            detour_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HELD = 2'd1,
        LAST = 2'd2
    } vcState_t;

    // The backup port depends only on parameters, so it collapses to a constant.
    function automatic port_t pickBackup(input port_t inPort, input bit e, input bit w,
                                         input bit n, input bit s);
        port_t p;
        p = DROP;
        case (inPort)
            EAST: begin
                if (w)      p = WEST;
                else if (n) p = NORTH;
                else if (s) p = SOUTH;
            end
            NORTH: begin
                if (s)      p = SOUTH;
                else if (e) p = EAST;
                else if (w) p = WEST;
            end
            SOUTH: begin
                if (n)      p = NORTH;
                else if (e) p = EAST;
                else if (w) p = WEST;
            end
            default: begin
                if (e)      p = EAST;
                else if (w) p = WEST;
                else if (n) p = NORTH;
                else if (s) p = SOUTH;
            end
        endcase
        return p;
    endfunction

    localparam bit    HAS_EAST    = (int'(THIS_POS.x) + 1) < MESH_WIDTH;
    localparam bit    HAS_WEST    = int'(THIS_POS.x) > 0;
    localparam bit    HAS_NORTH   = (int'(THIS_POS.y) + 1) < MESH_HEIGHT;
    localparam bit    HAS_SOUTH   = int'(THIS_POS.y) > 0;
    localparam port_t BACKUP_PORT = pickBackup(IN_PORT, HAS_EAST, HAS_WEST, HAS_NORTH, HAS_SOUTH);

    vcState_t [NUM_VCS-1:0] vcState_q, vcState_d;
    port_t    [NUM_VCS-1:0] routePort_q, routePort_d;
    logic                   protoErr_q, protoErr_d;
    port_t                  newPort;
    logic signed [8:0]      dx, dy, dz;
    logic                   headHit, tailHit;
`ifdef RCU_DETOUR_CNT_EN
    logic                   fromBackup;
    logic                   headAccepted;
    logic [15:0]            detourCnt_q, detourCnt_d;
`endif

    always_comb begin
        newPort = LOCAL;
`ifdef RCU_DETOUR_CNT_EN
        fromBackup = 1'b0;
`endif
        dx = $signed({1'b0, head_dest.x}) - $signed({1'b0, THIS_POS.x});
        dy = $signed({1'b0, head_dest.y}) - $signed({1'b0, THIS_POS.y});
        dz = $signed({1'b0, head_dest.z}) - $signed({1'b0, THIS_POS.z});
        if (int'(head_dest.x) >= MESH_WIDTH || int'(head_dest.y) >= MESH_HEIGHT ||
            int'(head_dest.z) >= MESH_DEPTH) begin
            newPort = DROP;
        end else if (dz != 9'sd0) begin
            if (dz > 9'sd0 && !up_faulty) begin
                newPort = UP;
            end else if (dz < 9'sd0 && !down_faulty) begin
                newPort = DOWN;
            end else begin
                newPort = BACKUP_PORT;
`ifdef RCU_DETOUR_CNT_EN
                fromBackup = 1'b1;
`endif
            end
        end else if (dx != 9'sd0) begin
            newPort = (dx > 9'sd0) ? EAST : WEST;
        end else if (dy != 9'sd0) begin
            newPort = (dy > 9'sd0) ? NORTH : SOUTH;
        end else begin
            newPort = LOCAL;
        end
    end

    // A head whose VC index matches no channel is a protocol error too.
    always_comb begin
        vcState_d   = vcState_q;
        routePort_d = routePort_q;
        protoErr_d  = protoErr_q;
        headHit     = 1'b0;
        tailHit     = 1'b0;
`ifdef RCU_DETOUR_CNT_EN
        headAccepted = 1'b0;
`endif
        if (head_valid && int'(head_vc) >= NUM_VCS) protoErr_d = 1'b1;
        if (tail_valid && int'(tail_vc) >= NUM_VCS) protoErr_d = 1'b1;
        for (int v = 0; v < NUM_VCS; v++) begin
            headHit = head_valid && (head_vc == VCW'(v));
            tailHit = tail_valid && (tail_vc == VCW'(v));
            case (vcState_q[v])
                IDLE: begin
                    if (headHit) begin
                        routePort_d[v] = newPort;
                        vcState_d[v]   = tailHit ? LAST : HELD;
`ifdef RCU_DETOUR_CNT_EN
                        headAccepted   = 1'b1;
`endif
                    end else if (tailHit) begin
                        protoErr_d = 1'b1;
                    end
                end
                HELD: begin
                    if (headHit) protoErr_d = 1'b1;
                    if (tailHit) vcState_d[v] = IDLE;
                end
                default: begin
                    if (headHit) protoErr_d = 1'b1;
                    vcState_d[v] = IDLE;
                end
            endcase
        end
    end

`ifdef RCU_DETOUR_CNT_EN
    always_comb begin
        detourCnt_d = detourCnt_q;
        if (headAccepted && fromBackup && detourCnt_q != 16'hFFFF) begin
            detourCnt_d = detourCnt_q + 16'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int v = 0; v < NUM_VCS; v++) begin
                vcState_q[v]   <= IDLE;
                routePort_q[v] <= LOCAL;
            end
            protoErr_q <= 1'b0;
`ifdef RCU_DETOUR_CNT_EN
            detourCnt_q <= 16'd0;
`endif
        end else begin
            vcState_q   <= vcState_d;
            routePort_q <= routePort_d;
            protoErr_q  <= protoErr_d;
`ifdef RCU_DETOUR_CNT_EN
            detourCnt_q <= detourCnt_d;
`endif
        end
    end

    always_comb begin
        route_valid = '0;
        for (int v = 0; v < NUM_VCS; v++) begin
            route_valid[v] = (vcState_q[v] != IDLE);
        end
    end

    assign route_port = routePort_q;
    assign proto_err  = protoErr_q;
`ifdef RCU_DETOUR_CNT_EN
    assign detour_cnt = detourCnt_q;
`endif

endmodule

// File: tb/tb_rcu_vc_pipe.sv
// Testbench for rcu_vc_pipe: route table on two routers plus hand-written VC lifecycle sequences.
// Build with RCU_DETOUR_CNT_EN defined to also cover the detour counter.

module tb_rcu_vc_pipe;
    import rcu_vc_pipe_pkg::*;

    logic      clk;
    logic      rst;
    logic      head_valid;
    logic [1:0] head_vc;
    position_t head_dest;
    logic      tail_valid;
    logic [1:0] tail_vc;
    logic      up_faulty;
    logic      down_faulty;

    logic [3:0]       validA, validB, validC, validE;
    logic [2:0]       validD;
    port_t [3:0]      portA, portB, portC, portE;
    port_t [2:0]      portD;
    logic             protoA, protoB, protoC, protoD, protoE;
`ifdef RCU_DETOUR_CNT_EN
    logic [15:0]      detA, detB, detC, detD, detE;
`endif

    int nChecks   = 0;
    int nFailures = 0;

    typedef struct {
        position_t dest;
        logic      up;
        logic      down;
        port_t     expA;
        port_t     expE;
    } vec_t;

    typedef struct {
        port_t a;
        port_t e;
    } exp_t;

    vec_t vecs[15];
    exp_t sbQ[$];

    rcu_vc_pipe #(.MESH_WIDTH(4), .MESH_HEIGHT(4), .MESH_DEPTH(2), .NUM_VCS(4), .IN_PORT(LOCAL),
                  .THIS_POS('{x: 8'd1, y: 8'd1, z: 8'd0})) dutA (
        .clk(clk), .rst(rst), .head_valid(head_valid), .head_vc(head_vc), .head_dest(head_dest),
        .tail_valid(tail_valid), .tail_vc(tail_vc), .up_faulty(up_faulty), .down_faulty(down_faulty),
        .route_valid(validA), .route_port(portA), .proto_err(protoA)
`ifdef RCU_DETOUR_CNT_EN
        , .detour_cnt(detA)
`endif
    );

    rcu_vc_pipe #(.MESH_WIDTH(4), .MESH_HEIGHT(4), .MESH_DEPTH(2), .NUM_VCS(4), .IN_PORT(EAST),
                  .THIS_POS('{x: 8'd1, y: 8'd1, z: 8'd0})) dutB (
        .clk(clk), .rst(rst), .head_valid(head_valid), .head_vc(head_vc), .head_dest(head_dest),
        .tail_valid(tail_valid), .tail_vc(tail_vc), .up_faulty(up_faulty), .down_faulty(down_faulty),
        .route_valid(validB), .route_port(portB), .proto_err(protoB)
`ifdef RCU_DETOUR_CNT_EN
        , .detour_cnt(detB)
`endif
    );

    rcu_vc_pipe #(.MESH_WIDTH(4), .MESH_HEIGHT(4), .MESH_DEPTH(2), .NUM_VCS(4), .IN_PORT(EAST),
                  .THIS_POS('{x: 8'd0, y: 8'd3, z: 8'd0})) dutC (
        .clk(clk), .rst(rst), .head_valid(head_valid), .head_vc(head_vc), .head_dest(head_dest),
        .tail_valid(tail_valid), .tail_vc(tail_vc), .up_faulty(up_faulty), .down_faulty(down_faulty),
        .route_valid(validC), .route_port(portC), .proto_err(protoC)
`ifdef RCU_DETOUR_CNT_EN
        , .detour_cnt(detC)
`endif
    );

    // Degenerate 1x1 column with only three VCs, so head_vc=3 is out of range here.
    rcu_vc_pipe #(.MESH_WIDTH(1), .MESH_HEIGHT(1), .MESH_DEPTH(2), .NUM_VCS(3), .IN_PORT(EAST),
                  .THIS_POS('{x: 8'd0, y: 8'd0, z: 8'd0})) dutD (
        .clk(clk), .rst(rst), .head_valid(head_valid), .head_vc(head_vc), .head_dest(head_dest),
        .tail_valid(tail_valid), .tail_vc(tail_vc), .up_faulty(up_faulty), .down_faulty(down_faulty),
        .route_valid(validD), .route_port(portD), .proto_err(protoD)
`ifdef RCU_DETOUR_CNT_EN
        , .detour_cnt(detD)
`endif
    );

    rcu_vc_pipe #(.MESH_WIDTH(4), .MESH_HEIGHT(4), .MESH_DEPTH(2), .NUM_VCS(4), .IN_PORT(NORTH),
                  .THIS_POS('{x: 8'd3, y: 8'd3, z: 8'd1})) dutE (
        .clk(clk), .rst(rst), .head_valid(head_valid), .head_vc(head_vc), .head_dest(head_dest),
        .tail_valid(tail_valid), .tail_vc(tail_vc), .up_faulty(up_faulty), .down_faulty(down_faulty),
        .route_valid(validE), .route_port(portE), .proto_err(protoE)
`ifdef RCU_DETOUR_CNT_EN
        , .detour_cnt(detE)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic position_t mkPos(input int x, input int y, input int z);
        position_t p;
        p.x = 8'(x);
        p.y = 8'(y);
        p.z = 8'(z);
        return p;
    endfunction

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFailures++;
            $display("[TB] FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearInputs();
        head_valid  = 1'b0;
        head_vc     = 2'd0;
        head_dest   = mkPos(0, 0, 0);
        tail_valid  = 1'b0;
        tail_vc     = 2'd0;
        up_faulty   = 1'b0;
        down_faulty = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Single-flit packet on vc0: route appears for exactly one cycle.
    task automatic applyStimulus(input vec_t v);
        exp_t e;
        head_valid  = 1'b1;
        head_vc     = 2'd0;
        head_dest   = v.dest;
        tail_valid  = 1'b1;
        tail_vc     = 2'd0;
        up_faulty   = v.up;
        down_faulty = v.down;
        e.a = v.expA;
        e.e = v.expE;
        sbQ.push_back(e);
        tick();
        clearInputs();
    endtask

    task automatic checkOutput(input int idx);
        exp_t e;
        if (sbQ.size() == 0) begin
            nChecks++;
            nFailures++;
            $display("[TB] FAIL sb_empty vec=%0d actual=0 required=1", idx);
        end else begin
            e = sbQ.pop_front();
            checkVal($sformatf("vec%0d_portA", idx), portA[0], e.a);
            checkVal($sformatf("vec%0d_portE", idx), portE[0], e.e);
            checkVal($sformatf("vec%0d_validA", idx), validA[0], 1);
            checkVal($sformatf("vec%0d_validE", idx), validE[0], 1);
            tick();
            checkVal($sformatf("vec%0d_pulseEnd", idx), {validA[0], validE[0]}, 0);
        end
    endtask

    initial begin
        vecs[0]  = '{mkPos(3,1,1), 1'b0, 1'b0, UP,    SOUTH};
        vecs[1]  = '{mkPos(3,1,1), 1'b1, 1'b0, EAST,  SOUTH};
        vecs[2]  = '{mkPos(1,1,0), 1'b0, 1'b0, LOCAL, DOWN};
        vecs[3]  = '{mkPos(1,1,0), 1'b0, 1'b1, LOCAL, SOUTH};
        vecs[4]  = '{mkPos(0,1,0), 1'b0, 1'b0, WEST,  DOWN};
        vecs[5]  = '{mkPos(1,3,0), 1'b0, 1'b0, NORTH, DOWN};
        vecs[6]  = '{mkPos(1,0,0), 1'b0, 1'b0, SOUTH, DOWN};
        vecs[7]  = '{mkPos(2,3,0), 1'b0, 1'b0, EAST,  DOWN};
        vecs[8]  = '{mkPos(4,0,0), 1'b0, 1'b0, DROP,  DROP};
        vecs[9]  = '{mkPos(0,4,0), 1'b0, 1'b0, DROP,  DROP};
        vecs[10] = '{mkPos(0,0,2), 1'b0, 1'b0, DROP,  DROP};
        vecs[11] = '{mkPos(3,3,1), 1'b0, 1'b0, UP,    LOCAL};
        vecs[12] = '{mkPos(3,3,1), 1'b1, 1'b1, EAST,  LOCAL};
        vecs[13] = '{mkPos(2,3,1), 1'b0, 1'b0, UP,    WEST};
        vecs[14] = '{mkPos(3,3,0), 1'b1, 1'b1, EAST,  SOUTH};

        clearInputs();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        checkVal("rst_valid", validA, 0);
        checkVal("rst_port", 32'(portA), 0);
        checkVal("rst_proto", protoA, 0);

        for (int i = 0; i < 15; i++) begin
            applyStimulus(vecs[i]);
            checkOutput(i);
        end
        checkVal("table_protoA", protoA, 0);
        checkVal("table_protoE", protoE, 0);

        // Multi-flit packet holds its route until the tail leaves.
        head_valid = 1'b1; head_vc = 2'd0; head_dest = mkPos(3, 1, 1);
        tick();
        clearInputs();
        checkVal("held_valid", validA[0], 1);
        checkVal("held_port", portA[0], UP);
        tick();
        tick();
        checkVal("held_persist", validA[0], 1);
        tail_valid = 1'b1; tail_vc = 2'd0;
        tick();
        clearInputs();
        checkVal("tail_drop_valid", validA[0], 0);
        checkVal("tail_keep_port", portA[0], UP);

        head_valid = 1'b1; head_vc = 2'd2; head_dest = mkPos(0, 1, 0);
        tail_valid = 1'b1; tail_vc = 2'd2;
        tick();
        clearInputs();
        checkVal("single_valid", validA[2], 1);
        checkVal("single_port", portA[2], WEST);
        tick();
        checkVal("single_end", validA, 0);

        head_valid = 1'b1; head_vc = 2'd3; head_dest = mkPos(4, 0, 0);
        tick();
        clearInputs();
        checkVal("oob_port", portA[3], DROP);
        checkVal("oob_valid", validA, 4'b1000);
        checkVal("oob_proto", protoA, 0);
        checkVal("badvc_protoD", protoD, 1);

        // Head and tail on different VCs in the same cycle are independent.
        head_valid = 1'b1; head_vc = 2'd1; head_dest = mkPos(1, 3, 0);
        tail_valid = 1'b1; tail_vc = 2'd3;
        tick();
        clearInputs();
        checkVal("indep_valid", validA, 4'b0010);
        checkVal("indep_port1", portA[1], NORTH);
        checkVal("indep_port3", portA[3], DROP);
        checkVal("indep_proto", protoA, 0);

        tail_valid = 1'b1; tail_vc = 2'd0;
        tick();
        clearInputs();
        checkVal("idle_tail_proto", protoA, 1);
        checkVal("idle_tail_valid", validA, 4'b0010);

        head_valid = 1'b1; head_vc = 2'd2; head_dest = mkPos(3, 1, 1);
        tick();
        clearInputs();
        checkVal("two_held", validA, 4'b0110);
        doReset();
        checkVal("midrst_valid", validA, 0);
        checkVal("midrst_proto", protoA, 0);
        checkVal("midrst_port", 32'(portA), 0);
        checkVal("midrst_protoD", protoD, 0);

        // A fault change while held must not disturb the latched route.
        head_valid = 1'b1; head_vc = 2'd0; head_dest = mkPos(1, 3, 0);
        tick();
        clearInputs();
        checkVal("fault_first_port", portA[0], NORTH);
        down_faulty = 1'b1;
        tick();
        head_valid = 1'b1; head_vc = 2'd0; head_dest = mkPos(3, 1, 1);
        tick();
        clearInputs();
        checkVal("rehead_port", portA[0], NORTH);
        checkVal("rehead_valid", validA[0], 1);
        checkVal("rehead_proto", protoA, 1);

        doReset();
        head_valid = 1'b1; head_vc = 2'd1; head_dest = mkPos(0, 0, 1); up_faulty = 1'b1;
        tick();
        clearInputs();
        checkVal("backup_B", portB[1], WEST);
        checkVal("backup_C", portC[1], SOUTH);
        checkVal("backup_D", portD[1], DROP);
        checkVal("backup_A", portA[1], EAST);
        checkVal("backup_validD", validD, 3'b010);
`ifdef RCU_DETOUR_CNT_EN
        checkVal("detour_sum", 32'(detB) + 32'(detC) + 32'(detD), 3);
        checkVal("detour_A", detA, 1);
        checkVal("detour_E", detE, 0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", nChecks, nFailures);
        $finish;
    end

endmodule
